// File: rtl/mu0_pkg.sv
// mu0_pkg: shared definitions for the MU0 sequencer slice.
//   - Opcode constants (IR[15:12]) OP_LDA..OP_STP; 8-F are no-ops.
//   - ALU mode constants driven on alu_m.
//   - Sequencer state encoding. ST_WAIT is only reachable when the
//     MU0_STEP_EN build macro is defined.
//   - Y-operand select used between decode and the datapath.
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [1:0] ALU_PASS_Y = 2'b00;
  localparam logic [1:0] ALU_ADD    = 2'b01;
  localparam logic [1:0] ALU_INC    = 2'b10;
  localparam logic [1:0] ALU_SUB    = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    YSEL_ZERO  = 2'd0,
    YSEL_RDATA = 2'd1,
    YSEL_ADDR  = 2'd2
  } ysel_t;

endpackage

// File: rtl/mu0_decode.sv
// mu0_decode: combinational control for the MU0 sequencer. Maps the
// current state, opcode and ACC flags onto memory request controls, ALU
// mode/operand selects, register load enables and the next state.
// Build macro: MU0_STEP_EN adds the step input and routes completed
// instructions through ST_WAIT.
// Ports:
//   state      in   current sequencer state
//   opcode     in   IR[15:12]
//   acc_zero   in   ACC == 0
//   acc_neg    in   ACC[15]
//   mem_ack    in   memory handshake acknowledge
//   step       in   (MU0_STEP_EN only) leave WAIT
//   req, wr    out  memory request / write
//   alu_m      out  ALU mode
//   use_pc     out  1 = PC drives alu_x and mem_addr (fetch)
//   ysel       out  alu_y source
//   ld_ir, ld_pc, ld_acc  out  register load enables
//   next_state out  state for the next cycle
module mu0_decode
  import mu0_pkg::*;
(
  input  state_t      state,
  input  logic [3:0]  opcode,
  input  logic        acc_zero,
  input  logic        acc_neg,
  input  logic        mem_ack,
`ifdef MU0_STEP_EN
  input  logic        step,
`endif
  output logic        req,
  output logic        wr,
  output logic [1:0]  alu_m,
  output logic        use_pc,
  output ysel_t       ysel,
  output logic        ld_ir,
  output logic        ld_pc,
  output logic        ld_acc,
  output state_t      next_state
);

  // Where a completed (non-STP) instruction goes next.
`ifdef MU0_STEP_EN
  localparam state_t ST_DONE = ST_WAIT;
`else
  localparam state_t ST_DONE = ST_FETCH;
`endif

  always_comb begin
    req        = 1'b0;
    wr         = 1'b0;
    alu_m      = ALU_PASS_Y;
    use_pc     = 1'b0;
    ysel       = YSEL_ZERO;
    ld_ir      = 1'b0;
    ld_pc      = 1'b0;
    ld_acc     = 1'b0;
    next_state = state;

    case (state)
      ST_FETCH: begin
        req    = 1'b1;
        use_pc = 1'b1;
        alu_m  = ALU_INC;
        if (mem_ack) begin
          ld_ir      = 1'b1;
          ld_pc      = 1'b1;
          next_state = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            req  = 1'b1;
            ysel = YSEL_RDATA;
            if (opcode == OP_ADD)      alu_m = ALU_ADD;
            else if (opcode == OP_SUB) alu_m = ALU_SUB;
            else                       alu_m = ALU_PASS_Y;
            if (mem_ack) begin
              ld_acc     = 1'b1;
              next_state = ST_DONE;
            end
          end
          OP_STA: begin
            req = 1'b1;
            wr  = 1'b1;
            if (mem_ack) next_state = ST_DONE;
          end
          // Branches pass S through the ALU; the flags reflect ACC as held
          // at the start of EXEC because ACC is not written this cycle.
          OP_JMP, OP_JGE, OP_JNE: begin
            ysel = YSEL_ADDR;
            if (opcode == OP_JMP)      ld_pc = 1'b1;
            else if (opcode == OP_JGE) ld_pc = ~acc_neg;
            else                       ld_pc = ~acc_zero;
            next_state = ST_DONE;
          end
          OP_STP:  next_state = ST_HALT;
          default: next_state = ST_DONE;
        endcase
      end

      ST_HALT: next_state = ST_HALT;

`ifdef MU0_STEP_EN
      ST_WAIT: if (step) next_state = ST_FETCH;
`endif

      default: next_state = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/mu0_sequencer.sv
// mu0_sequencer: MU0 fetch/execute control with the architectural
// registers PC, IR and ACC. Drives the external ALU (alu_x/alu_y/alu_m),
// registers its result alu_q, and runs a req/ack handshake to a
// single-port 16-bit memory.
// Build macro: MU0_STEP_EN adds input step; after each completed
// instruction (except STP) the sequencer idles until step is seen high.
// Ports:
//   Clk, Reset       clock; synchronous active-high reset
//   step             (MU0_STEP_EN only) single-step advance
//   mem_req/mem_wr/mem_addr/mem_wdata  memory request side
//   mem_ack/mem_rdata                  memory response side
//   alu_x/alu_y/alu_m                  ALU operands and mode
//   alu_q                              ALU result
//   halted, dbg_pc, dbg_acc            status / debug
module mu0_sequencer
  import mu0_pkg::*;
#(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        Clk,
  input  logic        Reset,
`ifdef MU0_STEP_EN
  input  logic        step,
`endif
  output logic        mem_req,
  output logic        mem_wr,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [1:0]  alu_m,
  input  logic [15:0] alu_q,
  output logic        halted,
  output logic [11:0] dbg_pc,
  output logic [15:0] dbg_acc
);

  state_t      state;
  state_t      next_state;
  logic [11:0] pc;
  logic [15:0] ir;
  logic [15:0] acc;

  logic        req;
  logic        wr;
  logic        use_pc;
  ysel_t       ysel;
  logic        ld_ir;
  logic        ld_pc;
  logic        ld_acc;

  mu0_decode u_decode (
    .state      (state),
    .opcode     (ir[15:12]),
    .acc_zero   (acc == 16'h0000),
    .acc_neg    (acc[15]),
    .mem_ack    (mem_ack),
`ifdef MU0_STEP_EN
    .step       (step),
`endif
    .req        (req),
    .wr         (wr),
    .alu_m      (alu_m),
    .use_pc     (use_pc),
    .ysel       (ysel),
    .ld_ir      (ld_ir),
    .ld_pc      (ld_pc),
    .ld_acc     (ld_acc),
    .next_state (next_state)
  );

  // Reset cuts the request in the same cycle so an in-flight transfer is
  // abandoned. Load enables only assert in request states on ack, or in
  // branch EXEC cycles, so a stray ack with no request has no effect.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      ir    <= 16'h0000;
      acc   <= 16'h0000;
    end else begin
      state <= next_state;
      if (ld_ir)  ir  <= mem_rdata;
      if (ld_pc)  pc  <= alu_q[11:0];
      if (ld_acc) acc <= alu_q;
    end
  end

  always_comb begin
    mem_req   = req & ~Reset;
    mem_wr    = wr;
    mem_addr  = use_pc ? pc : ir[11:0];
    mem_wdata = acc;
    alu_x     = use_pc ? {4'b0000, pc} : acc;
    case (ysel)
      YSEL_RDATA: alu_y = mem_rdata;
      YSEL_ADDR:  alu_y = {4'b0000, ir[11:0]};
      default:    alu_y = 16'h0000;
    endcase
    halted    = (state == ST_HALT) & ~Reset;
    dbg_pc    = pc;
    dbg_acc   = acc;
  end

endmodule

// File: tb/tb_mu0_sequencer.sv
// tb_mu0_sequencer: directed bench for mu0_sequencer with a behavioural
// ALU, a word memory with programmable ack delay, and a write recorder.
module tb_mu0_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        step = 1'b0;
  logic        mem_req, mem_wr, mem_ack, halted;
  logic [11:0] mem_addr, dbg_pc;
  logic [15:0] mem_wdata, mem_rdata, alu_x, alu_y, alu_q, dbg_acc;
  logic [1:0]  alu_m;

  logic [15:0] mem [0:4095];
  int          wait_n = 0;
  int          wcnt = 0;
  int          wr_cnt = 0;
  logic [11:0] wr_addr = 12'h000;
  logic [15:0] wr_data = 16'h0000;

  int checks = 0;
  int errors = 0;

  mu0_sequencer #(.RESET_PC(12'h000)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
`ifdef MU0_STEP_EN
    .step      (step),
`endif
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_m     (alu_m),
    .alu_q     (alu_q),
    .halted    (halted),
    .dbg_pc    (dbg_pc),
    .dbg_acc   (dbg_acc)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    case (alu_m)
      2'b00:   alu_q = alu_y;
      2'b01:   alu_q = alu_x + alu_y;
      2'b10:   alu_q = alu_x + 16'h0001;
      default: alu_q = alu_x - alu_y;
    endcase
  end

  assign mem_ack   = mem_req && (wcnt >= wait_n);
  assign mem_rdata = mem[mem_addr];

  always @(posedge Clk) begin
    if (mem_req && mem_ack) begin
      wcnt <= 0;
      if (mem_wr) begin
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
      end
    end else if (mem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
  endtask

  // Leaves the post-instruction idle state when single-step is built in.
  task automatic next_instr;
`ifdef MU0_STEP_EN
    step = 1'b1;
    tick();
    step = 1'b0;
    #1;
`endif
  endtask

  task automatic run_instr;
    tick();
    tick();
    next_instr();
  endtask

  task automatic test_reset;
    tick();
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", mem_req); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b exp 0", halted); end
    checks++; if (dbg_pc !== 12'h000) begin errors++; $display("FAIL rst_pc: got %h exp 000", dbg_pc); end
    checks++; if (dbg_acc !== 16'h0000) begin errors++; $display("FAIL rst_acc: got %h exp 0000", dbg_acc); end
    Reset = 1'b0;
    #1;
    checks++; if ({mem_req, mem_wr, mem_addr} !== {1'b1, 1'b0, 12'h000}) begin errors++; $display("FAIL rst_fetch: got req=%b wr=%b addr=%h exp 1 0 000", mem_req, mem_wr, mem_addr); end
    checks++; if ({alu_m, alu_x} !== {2'b10, 16'h0000}) begin errors++; $display("FAIL rst_fetch_alu: got m=%b x=%h exp 10 0000", alu_m, alu_x); end
  endtask

  task automatic test_lda_zero_wait;
    wait_n = 0;
    mem[12'h000] = 16'h0010;
    mem[12'h010] = 16'h1234;
    do_reset();
    tick();
    checks++; if (dbg_pc !== 12'h001) begin errors++; $display("FAIL lda_pc1: got %h exp 001", dbg_pc); end
    checks++; if (dbg_acc !== 16'h0000) begin errors++; $display("FAIL lda_acc1: got %h exp 0000", dbg_acc); end
    checks++; if ({mem_req, mem_addr, alu_m, alu_y} !== {1'b1, 12'h010, 2'b00, 16'h1234}) begin errors++; $display("FAIL lda_exec: got req=%b addr=%h m=%b y=%h exp 1 010 00 1234", mem_req, mem_addr, alu_m, alu_y); end
    tick();
    checks++; if (dbg_acc !== 16'h1234) begin errors++; $display("FAIL lda_acc2: got %h exp 1234", dbg_acc); end
    checks++; if (dbg_pc !== 12'h001) begin errors++; $display("FAIL lda_pc2: got %h exp 001", dbg_pc); end
    next_instr();
  endtask

  task automatic test_wait_states;
    mem[12'h000] = 16'h0012;
    mem[12'h012] = 16'hABCD;
    wait_n = 3;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if ({mem_req, mem_wr, mem_addr, dbg_pc} !== {1'b1, 1'b0, 12'h000, 12'h000}) begin errors++; $display("FAIL ws_fetch%0d: got req=%b wr=%b addr=%h pc=%h exp 1 0 000 000", i, mem_req, mem_wr, mem_addr, dbg_pc); end
    end
    tick();
    checks++; if ({dbg_pc, mem_addr} !== {12'h001, 12'h012}) begin errors++; $display("FAIL ws_fetched: got pc=%h addr=%h exp 001 012", dbg_pc, mem_addr); end
    for (int i = 5; i <= 7; i++) begin
      tick();
      checks++; if ({mem_req, mem_addr, dbg_acc} !== {1'b1, 12'h012, 16'h0000}) begin errors++; $display("FAIL ws_exec%0d: got req=%b addr=%h acc=%h exp 1 012 0000", i, mem_req, mem_addr, dbg_acc); end
    end
    tick();
    checks++; if (dbg_acc !== 16'hABCD) begin errors++; $display("FAIL ws_acc: got %h exp abcd", dbg_acc); end
    wait_n = 0;
    next_instr();
  endtask

  task automatic test_arith_wrap;
    wait_n = 0;
    mem[12'h000] = 16'h0030;
    mem[12'h001] = 16'h2031;
    mem[12'h002] = 16'h3031;
    mem[12'h030] = 16'hFFFF;
    mem[12'h031] = 16'h0001;
    do_reset();
    run_instr();
    checks++; if (dbg_acc !== 16'hFFFF) begin errors++; $display("FAIL ar_lda: got %h exp ffff", dbg_acc); end
    run_instr();
    checks++; if (dbg_acc !== 16'h0000) begin errors++; $display("FAIL ar_add_wrap: got %h exp 0000", dbg_acc); end
    run_instr();
    checks++; if (dbg_acc !== 16'hFFFF) begin errors++; $display("FAIL ar_sub_wrap: got %h exp ffff", dbg_acc); end
    checks++; if (dbg_pc !== 12'h003) begin errors++; $display("FAIL ar_pc: got %h exp 003", dbg_pc); end
  endtask

  task automatic test_branches;
    wait_n = 0;
    mem[12'h000] = 16'h0040;
    mem[12'h001] = 16'h5123;
    mem[12'h002] = 16'h0041;
    mem[12'h003] = 16'h6123;
    mem[12'h004] = 16'h0042;
    mem[12'h005] = 16'h6123;
    mem[12'h123] = 16'h40FF;
    mem[12'h0FF] = 16'h5200;
    mem[12'h200] = 16'h8000;
    mem[12'h040] = 16'h8000;
    mem[12'h041] = 16'h0000;
    mem[12'h042] = 16'h0005;
    do_reset();
    run_instr();
    run_instr();
    checks++; if (dbg_pc !== 12'h002) begin errors++; $display("FAIL br_jge_neg: got pc=%h exp 002", dbg_pc); end
    run_instr();
    run_instr();
    checks++; if (dbg_pc !== 12'h004) begin errors++; $display("FAIL br_jne_zero: got pc=%h exp 004", dbg_pc); end
    run_instr();
    run_instr();
    checks++; if (dbg_pc !== 12'h123) begin errors++; $display("FAIL br_jne_taken: got pc=%h exp 123", dbg_pc); end
    tick();
    checks++; if ({mem_req, alu_m, alu_y} !== {1'b0, 2'b00, 16'h00FF}) begin errors++; $display("FAIL br_jmp_exec: got req=%b m=%b y=%h exp 0 00 00ff", mem_req, alu_m, alu_y); end
    tick();
    next_instr();
    checks++; if (dbg_pc !== 12'h0FF) begin errors++; $display("FAIL br_jmp: got pc=%h exp 0ff", dbg_pc); end
    run_instr();
    checks++; if (dbg_pc !== 12'h200) begin errors++; $display("FAIL br_jge_pos: got pc=%h exp 200", dbg_pc); end
    run_instr();
    checks++; if ({dbg_pc, dbg_acc} !== {12'h201, 16'h0005}) begin errors++; $display("FAIL br_nop: got pc=%h acc=%h exp 201 0005", dbg_pc, dbg_acc); end
  endtask

  task automatic test_sta_stp;
    int wc0;
    wait_n = 0;
    mem[12'h000] = 16'h0050;
    mem[12'h001] = 16'h1020;
    mem[12'h002] = 16'h7000;
    mem[12'h050] = 16'hBEEF;
    do_reset();
    run_instr();
    wc0 = wr_cnt;
    tick();
    checks++; if ({mem_req, mem_wr, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'h020, 16'hBEEF}) begin errors++; $display("FAIL sta_req: got req=%b wr=%b addr=%h wdata=%h exp 1 1 020 beef", mem_req, mem_wr, mem_addr, mem_wdata); end
    tick();
    checks++; if ({wr_cnt, wr_addr, wr_data} !== {wc0 + 1, 12'h020, 16'hBEEF}) begin errors++; $display("FAIL sta_write: got n=%0d addr=%h data=%h exp %0d 020 beef", wr_cnt, wr_addr, wr_data, wc0 + 1); end
    checks++; if (dbg_acc !== 16'hBEEF) begin errors++; $display("FAIL sta_acc: got %h exp beef", dbg_acc); end
    next_instr();
    tick();
    tick();
    checks++; if ({halted, dbg_pc, mem_req} !== {1'b1, 12'h003, 1'b0}) begin errors++; $display("FAIL stp_halt: got halted=%b pc=%h req=%b exp 1 003 0", halted, dbg_pc, mem_req); end
    step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({halted, dbg_pc, mem_req} !== {1'b1, 12'h003, 1'b0}) begin errors++; $display("FAIL stp_hold%0d: got halted=%b pc=%h req=%b exp 1 003 0", i, halted, dbg_pc, mem_req); end
    end
    step = 1'b0;
    Reset = 1'b1;
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL stp_reset: got halted=%b exp 0", halted); end
    tick();
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_fetch;
    wait_n = 0;
    mem[12'h000] = 16'h4077;
    do_reset();
    run_instr();
    checks++; if (dbg_pc !== 12'h077) begin errors++; $display("FAIL rmf_jmp: got pc=%h exp 077", dbg_pc); end
    wait_n = 100;
    tick();
    tick();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 12'h077}) begin errors++; $display("FAIL rmf_stall: got req=%b addr=%h exp 1 077", mem_req, mem_addr); end
    Reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmf_req_drop: got %b exp 0", mem_req); end
    tick();
    checks++; if (dbg_pc !== 12'h000) begin errors++; $display("FAIL rmf_pc: got %h exp 000", dbg_pc); end
    Reset = 1'b0;
    #1;
    checks++; if ({mem_req, mem_wr, mem_addr} !== {1'b1, 1'b0, 12'h000}) begin errors++; $display("FAIL rmf_refetch: got req=%b wr=%b addr=%h exp 1 0 000", mem_req, mem_wr, mem_addr); end
    wait_n = 0;
  endtask

`ifdef MU0_STEP_EN
  task automatic test_step;
    wait_n = 0;
    mem[12'h000] = 16'h8000;
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL step_idle%0d: got req=%b exp 0", i, mem_req); end
      tick();
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    #1;
    checks++; if ({mem_req, mem_addr} !== {1'b1, 12'h001}) begin errors++; $display("FAIL step_go: got req=%b addr=%h exp 1 001", mem_req, mem_addr); end
  endtask
`endif

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 16'h8000;
    test_reset();
    test_lda_zero_wait();
    test_wait_states();
    test_arith_wrap();
    test_branches();
    test_sta_stp();
    test_reset_mid_fetch();
`ifdef MU0_STEP_EN
    test_step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mu0_sequencer.md
Name: mu0_sequencer

Overview:
- Multi-cycle fetch/execute control plus architectural registers (PC, IR, ACC) for the MU0 processor.
- Drives the MU0 ALU operands and mode (X, Y, M) and consumes its result Q.
- Talks to a single-port 16-bit memory over a req/ack handshake.
- Sits between memory and the ALU: it is both upstream of the ALU (supplies X/Y/M) and downstream of it (registers Q).

Parameters:
- RESET_PC, 12'h000, PC value loaded on reset.

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- mem_req  output  1  memory request, held until mem_ack
- mem_wr  output  1  1 = write, 0 = read; valid while mem_req
- mem_addr  output  12  word address; stable while mem_req
- mem_wdata  output  16  write data (ACC); valid while mem_req && mem_wr
- mem_ack  input  1  transfer completes in any cycle where mem_req && mem_ack
- mem_rdata  input  16  read data; sampled only in the ack cycle
- alu_x  output  16  ALU X operand
- alu_y  output  16  ALU Y operand
- alu_m  output  2  ALU mode: 00 Q=Y, 01 X+Y, 10 X+1, 11 X-Y
- alu_q  input  16  ALU result (combinational from alu_x/alu_y/alu_m)
- halted  output  1  high in HALT state
- dbg_pc  output  12  current PC
- dbg_acc  output  16  current ACC

Behaviour:
- ISA: IR[15:12] is the opcode and IR[11:0] is the operand address S.
  - 0 LDA: ACC = mem[S]
  - 1 STA: mem[S] = ACC
  - 2 ADD: ACC += mem[S]
  - 3 SUB: ACC -= mem[S]
  - 4 JMP: PC = S
  - 5 JGE: if ACC[15] == 0, PC = S
  - 6 JNE: if ACC != 0, PC = S
  - 7 STP: halt
  - 8-F: no-op
- Reset:
  - PC = RESET_PC, IR = 0, ACC = 0, state = FETCH.
  - mem_req is forced 0 and halted = 0 during any cycle with Reset high.
  - Reset mid-handshake abandons the transfer; mem_req drops in the Reset cycle.
- States: FETCH, EXEC, HALT.
- FETCH:
  - mem_req = 1, mem_wr = 0, mem_addr = PC.
  - ALU inputs: alu_x = {4'b0, PC}, alu_m = 10.
  - Each cycle without ack: hold all outputs and stay in FETCH.
  - On ack: IR <= mem_rdata, PC <= alu_q[11:0] (wraps FFF -> 000), go to EXEC.
- EXEC, LDA/ADD/SUB:
  - mem_req = 1, mem_wr = 0, mem_addr = S.
  - ALU inputs: alu_x = ACC, alu_y = mem_rdata.
  - alu_m = 00 for LDA, 01 for ADD, 11 for SUB.
  - On ack: ACC <= alu_q (16-bit, modulo 2^16), go to FETCH.
- EXEC, STA:
  - mem_req = 1, mem_wr = 1, mem_addr = S, mem_wdata = ACC.
  - On ack: go to FETCH; ACC unchanged.
- EXEC, JMP/JGE/JNE:
  - No memory request; one cycle.
  - ALU inputs: alu_y = {4'b0, S}, alu_m = 00.
  - PC <= alu_q[11:0] if the branch is taken, else PC unchanged; go to FETCH.
  - JGE and JNE test the ACC value held at the start of EXEC.
- EXEC, STP: go to HALT.
- EXEC, 8-F: go to FETCH, no side effects.
- HALT:
  - No requests; registers frozen.
  - Stays in HALT until Reset.
  - PC already points past the STP instruction.
- ALU outputs when unused (HALT, and fields not listed above): alu_x = ACC, alu_y = 0, alu_m = 00.
- Latency with zero-wait memory (ack in the same cycle as req):
  - Fetch: 1 cycle.
  - LDA/ADD/SUB/STA: 2 cycles.
  - Jumps and no-ops: 2 cycles.
- Each wait cycle adds exactly 1 cycle.
- mem_ack while mem_req = 0 is ignored.

Optional Feature:
- Macro: MU0_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - Adds state WAIT, entered instead of FETCH after every completed instruction except STP.
  - WAIT issues no requests.
  - The first cycle with step high moves to FETCH.
  - Reset still goes directly to FETCH.
- Undefined: no step port and no WAIT state; behaviour exactly as above.

Decomposition:
- Shared package mu0_pkg holds:
  - Opcode constants OP_LDA..OP_STP.
  - ALU mode constants ALU_PASS_Y = 2'b00, ALU_ADD = 2'b01, ALU_INC = 2'b10, ALU_SUB = 2'b11.
  - State encoding.
- Natural sub-module: mu0_decode, a combinational mapping of opcode plus ACC flags to alu_m, mem_req/mem_wr, branch-taken and next-state controls.
- Registers stay in mu0_sequencer.

Test Plan:
- Reset and zero-wait fetch: Reset, mem[000] = 16'h0010, mem[010] = 16'h1234 -> LDA completes in 2 cycles, ACC = 1234, PC = 001.
- Wait states: ack delayed 3 cycles on both the fetch and the operand read -> mem_req/mem_addr stable throughout, instruction takes 8 cycles, result correct.
- Arithmetic wrap: ACC = FFFF, ADD with mem = 0001 -> ACC = 0000. Then SUB with mem = 0001 -> ACC = FFFF.
- Branches:
  - ACC = 8000, JGE 123 -> PC unchanged.
  - ACC = 0000, JNE 123 -> not taken.
  - ACC = 0005, JNE 123 -> PC = 123.
  - JMP 0FF -> PC = 0FF.
- STA then STP: STA 020 with ACC = BEEF -> write of BEEF to 020 observed. STP -> halted = 1, no further mem_req, PC = STP address + 1.
- Reset mid-fetch with ack withheld: Reset -> mem_req = 0 in the Reset cycle, PC = RESET_PC, fetch restarts. With MU0_STEP_EN defined: no fetch occurs until step is pulsed.
